// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM state and SPI mode encodings for the SPI master.
package spi_pkg;
   typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_e;
   typedef enum logic [1:0] {MODE0 = 2'b00, MODE1 = 2'b01, MODE2 = 2'b10, MODE3 = 2'b11} spi_mode_e;
endpackage

// File: rtl/spi_clk_gen.sv
// spi_clk_gen: emits a one-cycle tick every div_i+1 cycles while enabled; count is held at zero when disabled.
module spi_clk_gen
   import spi_pkg::*;
#(
   parameter int DIV_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic [DIV_W-1:0] div_i,
   output logic             tick_o
);
   logic [DIV_W-1:0] cnt_q, cnt_d;
   assign tick_o = en_i && cnt_q == div_i;
   always_comb cnt_d = (!en_i || tick_o) ? '0 : cnt_q + 1'b1;
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) cnt_q <= '0;
      else cnt_q <= cnt_d;
endmodule

// File: rtl/spi_master_param.sv
// spi_master_param: parameterised SPI master, all four modes, MSB first, per-transfer latched configuration.
module spi_master_param
   import spi_pkg::*;
#(
   parameter  int DATA_W = 8,
   parameter  int NUM_CS = 4,
   parameter  int DIV_W  = 8,
   localparam int CS_W   = NUM_CS > 1 ? $clog2(NUM_CS) : 1
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              start_i,
   input  logic [DATA_W-1:0] tx_data_i,
   input  logic [CS_W-1:0]   cs_sel_i,
   input  logic              cpol_i,
   input  logic              cpha_i,
   input  logic [DIV_W-1:0]  clk_div_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [DATA_W-1:0] rx_data_o,
   output logic              sclk_o,
   output logic              mosi_o,
   input  logic              miso_i,
   output logic [NUM_CS-1:0] nss_o
);
   localparam int EC_W = $clog2(2 * DATA_W + 1);
   state_e            state_q, state_d;
   spi_mode_e         mode_q, mode_d;
   logic [CS_W-1:0]   cs_q, cs_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [DATA_W-1:0] sh_q, sh_d, rsh_q, rsh_d, rx_q, rx_d;
   logic [EC_W-1:0]   ecnt_q, ecnt_d;
   logic              sclk_q, sclk_d, mosi_q, mosi_d, done_q, done_d, arm_q;
   logic              tick, edge_ev, samp;
   spi_clk_gen #(.DIV_W(DIV_W)) u_clk_gen (
      .clk_i  (clk_i),
      .rst_i  (reset_i),
      .en_i   (busy_o),
      .div_i  (div_q),
      .tick_o (tick)
   );
   assign busy_o    = state_q != IDLE;
   assign done_o    = done_q;
   assign rx_data_o = rx_q;
   assign sclk_o    = sclk_q;
   assign mosi_o    = mosi_q;
   for (genvar i = 0; i < NUM_CS; i++) begin : g_nss
      assign nss_o[i] = !(busy_o && cs_q == CS_W'(i));
   end
   // The SETUP-ending tick is edge 0 (leading); the XFER tick after edge 2*DATA_W-1 only moves to HOLD.
   assign edge_ev = tick && (state_q == SETUP || (state_q == XFER && ecnt_q != EC_W'(2 * DATA_W)));
   assign samp    = ~ecnt_q[0] ^ mode_q[0];
   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      cs_d    = cs_q;
      div_d   = div_q;
      sh_d    = sh_q;
      rsh_d   = rsh_q;
      rx_d    = rx_q;
      ecnt_d  = ecnt_q;
      sclk_d  = sclk_q;
      mosi_d  = mosi_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: if (start_i && arm_q) begin
            state_d = SETUP;
            mode_d  = spi_mode_e'({cpol_i, cpha_i});
            cs_d    = cs_sel_i;
            div_d   = clk_div_i;
            sclk_d  = cpol_i;
            mosi_d  = cpha_i ? 1'b0 : tx_data_i[DATA_W-1];
            sh_d    = cpha_i ? tx_data_i : tx_data_i << 1;
            ecnt_d  = '0;
         end
         SETUP: state_d = tick ? XFER : SETUP;
         XFER:  state_d = tick && ecnt_q == EC_W'(2 * DATA_W) ? HOLD : XFER;
         HOLD: if (tick) begin
            state_d = IDLE;
            done_d  = 1'b1;
            rx_d    = rsh_q;
            sclk_d  = mode_q[1];
         end
      endcase
      if (edge_ev) begin
         ecnt_d = ecnt_q + 1'b1;
         sclk_d = ~sclk_q;
         rsh_d  = samp ? {rsh_q[DATA_W-2:0], miso_i} : rsh_q;
         mosi_d = samp ? mosi_q : sh_q[DATA_W-1];
         sh_d   = samp ? sh_q : sh_q << 1;
      end
   end
   always_ff @(posedge clk_i or posedge reset_i)
      if (reset_i) begin
         state_q <= IDLE;
         mode_q  <= MODE0;
         cs_q    <= '0;
         div_q   <= '0;
         sh_q    <= '0;
         rsh_q   <= '0;
         rx_q    <= '0;
         ecnt_q  <= '0;
         sclk_q  <= 1'b0;
         mosi_q  <= 1'b0;
         done_q  <= 1'b0;
         arm_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         cs_q    <= cs_d;
         div_q   <= div_d;
         sh_q    <= sh_d;
         rsh_q   <= rsh_d;
         rx_q    <= rx_d;
         ecnt_q  <= ecnt_d;
         sclk_q  <= sclk_d;
         mosi_q  <= mosi_d;
         done_q  <= done_d;
         arm_q   <= 1'b1;
      end
endmodule
